// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default character width and
// the LOG2_CEIL sizing helper used for index and counter widths.
package uart_pkg;

    localparam int UART_BITS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Smallest width able to index n items, never less than one bit.
    function automatic int LOG2_CEIL(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 16; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin winner search: scans upward from last_grant+1,
// wrapping modulo NREQ, and reports the first valid requester.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = LOG2_CEIL(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   winner,
    output logic            any_valid
);

    logic [GW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0] cand_hit;

    // cand_idx[k] is the requester examined k+1 places after the last winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_idx[gi] = GW'((int'(last_grant) + gi + 1) % NREQ);
            assign cand_hit[gi] = req_valid[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner    = cand_idx[k];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART Tx unit among NREQ word producers, MSB byte first.
// Optional trailing XOR checksum byte when UART_TX_ARB_CHECKSUM_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NREQ       = 2,
    parameter  int BITS       = UART_BITS,
    parameter  int WORD_WIDTH = 16,
    localparam int NPARTS     = WORD_WIDTH / BITS,
    localparam int GW         = LOG2_CEIL(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WORD_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       BaudTick,
    input  logic                       Busy,
    output logic                       TxD_start,
    output logic [BITS-1:0]            TxD_data,
    output logic [GW-1:0]              grant_id,
    output logic                       active
);

`ifdef UART_TX_ARB_CHECKSUM_EN
    localparam int LAST_PART = NPARTS;
`else
    localparam int LAST_PART = NPARTS - 1;
`endif
    localparam int PW = LOG2_CEIL(LAST_PART + 1);

    arb_state_t             state_reg;
    logic [WORD_WIDTH-1:0]  word_reg;
    logic [PW-1:0]          part_cnt_reg;
    logic [GW-1:0]          last_grant_reg;
    logic [GW-1:0]          grant_id_reg;
    logic [NREQ-1:0]        req_ready_reg;
    logic                   active_reg;
    logic                   txd_start_reg;
    logic [BITS-1:0]        txd_data_reg;

    logic [GW-1:0]          pick_winner;
    logic                   pick_any;
    logic [WORD_WIDTH-1:0]  req_word [NREQ];
    logic [WORD_WIDTH-1:0]  win_word;
    logic [NREQ-1:0]        win_onehot;
    logic [WORD_WIDTH-1:0]  word_shift;
    logic [BITS-1:0]        next_byte;
    logic                   last_part;

    uart_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .any_valid  (pick_any)
    );

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_word[gi]   = req_data[gi*WORD_WIDTH +: WORD_WIDTH];
            assign win_onehot[gi] = (pick_winner == GW'(gi));
        end
    endgenerate

    assign win_word   = req_word[pick_winner];
    assign word_shift = word_reg << BITS;
    assign last_part  = (part_cnt_reg == PW'(LAST_PART));

`ifdef UART_TX_ARB_CHECKSUM_EN
    logic [BITS-1:0] chk_reg;
    logic [BITS-1:0] win_xor [NPARTS+1];

    // XOR of every byte of the word about to be granted, latched with it.
    assign win_xor[0] = '0;
    generate
        for (genvar gi = 0; gi < NPARTS; gi++) begin : g_xor
            assign win_xor[gi+1] = win_xor[gi] ^ win_word[gi*BITS +: BITS];
        end
    endgenerate

    assign next_byte = (part_cnt_reg == PW'(NPARTS - 1)) ? chk_reg
                                                          : word_shift[WORD_WIDTH-1 -: BITS];
`else
    assign next_byte = word_shift[WORD_WIDTH-1 -: BITS];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            word_reg       <= '0;
            part_cnt_reg   <= '0;
            last_grant_reg <= GW'(NREQ - 1);
            grant_id_reg   <= '0;
            req_ready_reg  <= '0;
            active_reg     <= 1'b0;
            txd_start_reg  <= 1'b0;
            txd_data_reg   <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
            chk_reg        <= '0;
`endif
        end else begin
            req_ready_reg <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        word_reg       <= win_word;
                        grant_id_reg   <= pick_winner;
                        last_grant_reg <= pick_winner;
                        part_cnt_reg   <= '0;
                        active_reg     <= 1'b1;
                        req_ready_reg  <= win_onehot;
                        txd_data_reg   <= win_word[WORD_WIDTH-1 -: BITS];
`ifdef UART_TX_ARB_CHECKSUM_EN
                        chk_reg        <= win_xor[NPARTS];
`endif
                        state_reg      <= SEND;
                    end
                end
                SEND: begin
                    if (!Busy && BaudTick) begin
                        txd_start_reg <= 1'b1;
                        state_reg     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Start stays up until the Tx unit acknowledges by going busy.
                    if (Busy) begin
                        txd_start_reg <= 1'b0;
                        state_reg     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!Busy) begin
                        word_reg     <= word_shift;
                        part_cnt_reg <= part_cnt_reg + PW'(1);
                        if (last_part) begin
                            active_reg <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            txd_data_reg <= next_byte;
                            state_reg    <= SEND;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign grant_id  = grant_id_reg;
    assign active    = active_reg;
    assign TxD_start = txd_start_reg;
    assign TxD_data  = txd_data_reg;

endmodule
